// File: rtl/ldpc_pkg.sv
// ============================================================================
// Module : ldpc_pkg
// Brief  : Shared sizes and state encoding for the 20-VN / 10-CN LDPC decoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ldpc_pkg;

  localparam int N_VN     = 20;
  localparam int N_CN     = 10;
  localparam int LLR_W    = 3;
  localparam int AW       = 5;
  localparam int MAX_ITER = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CHECK  = 3'd2,
    UPDATE = 3'd3,
    DONE   = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/ldpc_decode_ctrl_if.sv
// ============================================================================
// Module : ldpc_decode_ctrl_if
// Brief  : Control bundle between the decode sequencer and the VN/CN units.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ldpc_decode_ctrl_if
  import ldpc_pkg::*;
#(
  parameter int AW_P = AW
);

  logic            decode;
  logic            ok_n;
  logic            en;
  logic            clk1;
  logic            clk2;
  logic            clk3;
  logic            clk4;
  logic            clk5;
  logic            clk6;
  logic            s1;
  logic            s2;
  logic            we;
  logic            re;
  logic [AW_P-1:0] waddr;
  logic [AW_P-1:0] raddr;
  logic [AW_P-1:0] number;
  logic [AW_P-1:0] times;

  modport master (
    input  decode, ok_n,
    output en, clk1, clk2, clk3, clk4, clk5, clk6,
           s1, s2, we, re, waddr, raddr, number, times
  );

  modport slave (
    output decode, ok_n,
    input  en, clk1, clk2, clk3, clk4, clk5, clk6,
           s1, s2, we, re, waddr, raddr, number, times
  );

endinterface

`default_nettype wire

// File: rtl/ldpc_decode_ctrl.sv
// ============================================================================
// Module : ldpc_decode_ctrl
// Brief  : Load / check / update sequencer for the LDPC decoder datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ldpc_decode_ctrl
  import ldpc_pkg::*;
#(
  parameter int N_VN_P     = N_VN,
  parameter int AW_P       = AW,
  parameter int MAX_ITER_P = MAX_ITER
) (
  input  logic                clk,
  input  logic                rst_n,
  ldpc_decode_ctrl_if.master  bus
);

  localparam int             IW       = $clog2(MAX_ITER_P + 1);
  localparam logic [AW_P-1:0] C_LAST  = AW_P'(N_VN_P - 1);
  localparam logic [AW_P-1:0] C_NVN   = AW_P'(N_VN_P);
  localparam logic [IW-1:0]   C_MAXIT = IW'(MAX_ITER_P);

  state_e          state_q, state_d;
  logic [AW_P-1:0] cnt_q,   cnt_d;
  logic            phase_q, phase_d;
  logic [IW-1:0]   iter_q,  iter_d;

  logic en_q, clk1_q, clk2_q, clk3_q, clk4_q, clk5_q, clk6_q;
  logic en_d, clk1_d, clk2_d, clk3_d, clk4_d, clk5_d, clk6_d;
  logic s1_q, s2_q, we_q, re_q;
  logic s1_d, s2_d, we_d, re_d;
  logic [AW_P-1:0] waddr_q, raddr_q, number_q, times_q;
  logic [AW_P-1:0] waddr_d, raddr_d, number_d, times_d;

  // cnt holds number in LOAD and times in UPDATE; phase is the check-cycle
  // bit in CHECK and the "hard-decision strobe already issued" bit in DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    iter_d   = iter_q;

    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        phase_d = 1'b0;
        iter_d  = '0;
        if (bus.decode) state_d = LOAD;
      end
      LOAD: begin
        if (cnt_q == C_LAST) begin
          state_d = CHECK;
          cnt_d   = '0;
          phase_d = 1'b0;
        end else begin
          cnt_d = cnt_q + AW_P'(1);
        end
      end
      CHECK: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (!bus.ok_n || (iter_q == C_MAXIT)) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            state_d = UPDATE;
            cnt_d   = AW_P'(1);
          end
        end
      end
      UPDATE: begin
        if (cnt_q == C_NVN) begin
          state_d = CHECK;
          cnt_d   = '0;
          phase_d = 1'b0;
          iter_d  = iter_q + IW'(1);
        end else begin
          cnt_d = cnt_q + AW_P'(1);
        end
      end
      DONE: begin
        cnt_d   = '0;
        phase_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        phase_d = 1'b0;
        iter_d  = '0;
      end
    endcase

    if (!bus.decode && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
      phase_d = 1'b0;
      iter_d  = '0;
    end

    // Outputs are decoded from the next state so they register in step with it.
    en_d     = 1'b0;
    clk1_d   = 1'b0;
    clk2_d   = 1'b0;
    clk3_d   = 1'b0;
    clk4_d   = 1'b0;
    clk5_d   = 1'b0;
    clk6_d   = 1'b0;
    s1_d     = 1'b0;
    s2_d     = 1'b0;
    we_d     = 1'b0;
    re_d     = 1'b0;
    waddr_d  = '0;
    raddr_d  = '0;
    number_d = '0;
    times_d  = '0;

    unique case (state_d)
      LOAD: begin
        en_d     = 1'b1;
        we_d     = 1'b1;
        clk1_d   = 1'b1;
        waddr_d  = cnt_d;
        number_d = cnt_d;
      end
      CHECK: begin
        en_d   = 1'b1;
        clk5_d = !phase_d;
        clk6_d = phase_d;
      end
      UPDATE: begin
        en_d     = 1'b1;
        re_d     = 1'b1;
        s1_d     = 1'b1;
        clk2_d   = 1'b1;
        clk3_d   = (cnt_d == C_NVN);
        times_d  = cnt_d;
        raddr_d  = cnt_d - AW_P'(1);
        number_d = cnt_d - AW_P'(1);
      end
      DONE: begin
        s2_d   = 1'b1;
        clk4_d = !phase_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      iter_q   <= '0;
      en_q     <= 1'b0;
      clk1_q   <= 1'b0;
      clk2_q   <= 1'b0;
      clk3_q   <= 1'b0;
      clk4_q   <= 1'b0;
      clk5_q   <= 1'b0;
      clk6_q   <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      waddr_q  <= '0;
      raddr_q  <= '0;
      number_q <= '0;
      times_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      iter_q   <= iter_d;
      en_q     <= en_d;
      clk1_q   <= clk1_d;
      clk2_q   <= clk2_d;
      clk3_q   <= clk3_d;
      clk4_q   <= clk4_d;
      clk5_q   <= clk5_d;
      clk6_q   <= clk6_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      we_q     <= we_d;
      re_q     <= re_d;
      waddr_q  <= waddr_d;
      raddr_q  <= raddr_d;
      number_q <= number_d;
      times_q  <= times_d;
    end
  end

  assign bus.en     = en_q;
  assign bus.clk1   = clk1_q;
  assign bus.clk2   = clk2_q;
  assign bus.clk3   = clk3_q;
  assign bus.clk4   = clk4_q;
  assign bus.clk5   = clk5_q;
  assign bus.clk6   = clk6_q;
  assign bus.s1     = s1_q;
  assign bus.s2     = s2_q;
  assign bus.we     = we_q;
  assign bus.re     = re_q;
  assign bus.waddr  = waddr_q;
  assign bus.raddr  = raddr_q;
  assign bus.number = number_q;
  assign bus.times  = times_q;

endmodule

`default_nettype wire

// File: tb/tb_ldpc_decode_ctrl.sv
// ============================================================================
// Module : tb_ldpc_decode_ctrl
// Brief  : Directed self-checking bench for the LDPC decode sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ldpc_decode_ctrl;

  // Output vector order: {en,clk1,clk2,clk3,clk4,clk5,clk6,s1,s2,we,re}
  localparam logic [10:0] C_ZERO  = 11'b0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [10:0] C_LOAD  = 11'b1_1_0_0_0_0_0_0_0_1_0;
  localparam logic [10:0] C_CHK0  = 11'b1_0_0_0_0_1_0_0_0_0_0;
  localparam logic [10:0] C_CHK1  = 11'b1_0_0_0_0_0_1_0_0_0_0;
  localparam logic [10:0] C_UPD   = 11'b1_0_1_0_0_0_0_1_0_0_1;
  localparam logic [10:0] C_UPDL  = 11'b1_0_1_1_0_0_0_1_0_0_1;
  localparam logic [10:0] C_DONE1 = 11'b0_0_0_0_1_0_0_0_1_0_0;
  localparam logic [10:0] C_DONE  = 11'b0_0_0_0_0_0_0_0_1_0_0;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   c3_seen;

  ldpc_decode_ctrl_if bus_if ();

  ldpc_decode_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] outs();
    return {bus_if.en, bus_if.clk1, bus_if.clk2, bus_if.clk3, bus_if.clk4,
            bus_if.clk5, bus_if.clk6, bus_if.s1, bus_if.s2, bus_if.we, bus_if.re};
  endfunction

  function automatic logic [19:0] cnts();
    return {bus_if.waddr, bus_if.raddr, bus_if.number, bus_if.times};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string tag, input logic [10:0] eo,
                            input int w, input int r, input int n, input int t);
    chk({tag, "_o"}, 32'(outs()), 32'(eo));
    chk({tag, "_c"}, 32'(cnts()), 32'({5'(w), 5'(r), 5'(n), 5'(t)}));
  endtask

  // Checks the current LOAD cycle for index i and advances one clock.
  task automatic load_cycle(input int i);
    expect_now("load", C_LOAD, i, 0, i, 0);
    tick();
  endtask

  task automatic check_phase(input logic okn);
    expect_now("chk0", C_CHK0, 0, 0, 0, 0);
    tick();
    bus_if.ok_n = okn;
    expect_now("chk1", C_CHK1, 0, 0, 0, 0);
    tick();
  endtask

  task automatic update_pass();
    for (int t = 1; t <= 20; t++) begin
      expect_now("upd", (t == 20) ? C_UPDL : C_UPD, 0, t - 1, t - 1, t);
      if (bus_if.clk3) c3_seen++;
      tick();
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    c3_seen       = 0;
    rst_n         = 1'b0;
    bus_if.decode = 1'b0;
    bus_if.ok_n   = 1'b1;

    tick();
    tick();
    expect_now("reset", C_ZERO, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Early parity success: load, one check, straight to DONE.
    tick();
    expect_now("idle", C_ZERO, 0, 0, 0, 0);
    bus_if.decode = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) load_cycle(i);
    check_phase(1'b0);
    expect_now("done1", C_DONE1, 0, 0, 0, 0);
    tick();
    expect_now("done", C_DONE, 0, 0, 0, 0);
    tick();
    expect_now("done_hold", C_DONE, 0, 0, 0, 0);
    bus_if.decode = 1'b0;
    tick();
    expect_now("done_exit", C_ZERO, 0, 0, 0, 0);

    // Parity never satisfied: eight update passes then give up.
    bus_if.ok_n   = 1'b1;
    bus_if.decode = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) load_cycle(i);
    for (int p = 0; p < 8; p++) begin
      check_phase(1'b1);
      update_pass();
    end
    check_phase(1'b1);
    expect_now("fail_done1", C_DONE1, 0, 0, 0, 0);
    chk("clk3_count", 32'(c3_seen), 32'd8);
    bus_if.decode = 1'b0;
    tick();
    expect_now("fail_exit", C_ZERO, 0, 0, 0, 0);

    // Success on the second evaluate: exactly one update pass.
    c3_seen       = 0;
    bus_if.decode = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) load_cycle(i);
    check_phase(1'b1);
    update_pass();
    check_phase(1'b0);
    expect_now("one_done1", C_DONE1, 0, 0, 0, 0);
    chk("one_clk3", 32'(c3_seen), 32'd1);
    bus_if.decode = 1'b0;
    tick();
    expect_now("one_exit", C_ZERO, 0, 0, 0, 0);

    // Abort during LOAD at index 7, then restart from zero.
    bus_if.decode = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) load_cycle(i);
    expect_now("load7", C_LOAD, 7, 0, 7, 0);
    bus_if.decode = 1'b0;
    tick();
    expect_now("abort", C_ZERO, 0, 0, 0, 0);
    bus_if.decode = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) load_cycle(i);

    // Asynchronous reset in the middle of an update pass (times = 11).
    bus_if.ok_n = 1'b1;
    check_phase(1'b1);
    for (int t = 1; t < 11; t++) begin
      expect_now("pre_rst", C_UPD, 0, t - 1, t - 1, t);
      tick();
    end
    expect_now("upd11", C_UPD, 0, 10, 10, 11);
    rst_n = 1'b0;
    #1;
    expect_now("async_rst", C_ZERO, 0, 0, 0, 0);
    #1;
    rst_n = 1'b1;
    tick();
    expect_now("fresh_load", C_LOAD, 0, 0, 0, 0);
    tick();
    expect_now("fresh_load1", C_LOAD, 1, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
